// File: rtl/fmap_streamer_if.sv
// -----------------------------------------------------------------------------
// fmap_streamer_if
//   Bundles the frame-request, memory-read and pixel-output signals of
//   fmap_streamer. The streamer uses the slave view. The master view belongs
//   to whatever drives frame requests and hold, and also supplies memory read
//   data.
//
//   start       frame request
//   base_addr   frame start address
//   hold        pause new memory reads
//   mem_rd_en   memory read strobe
//   mem_addr    memory read address
//   mem_rd_data signed read data, one cycle after mem_rd_en
//   out_valid   pixel present on out_data
//   out_data    signed pixel, row-major
//   out_eol     last column of a row
//   busy        frame in progress
//   done        final pixel of the frame
// -----------------------------------------------------------------------------
interface fmap_streamer_if #(
    parameter int In_d_W = 32,
    parameter int ADDR_W = 10
);
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic                     hold;
    logic                     mem_rd_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [In_d_W-1:0] mem_rd_data;
    logic                     out_valid;
    logic signed [In_d_W-1:0] out_data;
    logic                     out_eol;
    logic                     busy;
    logic                     done;

    modport master (
        output start, base_addr, hold, mem_rd_data,
        input  mem_rd_en, mem_addr, out_valid, out_data, out_eol, busy, done
    );

    modport slave (
        input  start, base_addr, hold, mem_rd_data,
        output mem_rd_en, mem_addr, out_valid, out_data, out_eol, busy, done
    );
endinterface

// File: rtl/fmap_streamer.sv
// -----------------------------------------------------------------------------
// fmap_streamer
//   Reads one W x H feature map from a memory with a one-cycle read latency.
//   Pixels come out in row-major order with a fixed two-cycle delay from read
//   to output. The hold input pauses address generation. Reads that are
//   already in flight still complete.
//
//   Parameters: In_d_W pixel width, W columns, H rows, ADDR_W address width.
//   Ports:      clk, clr (asynchronous, active-high), and bus
//               (fmap_streamer_if.slave, which carries start/base_addr/hold,
//               the memory read port and the pixel output).
//
//   Optional feature: define FMAP_STREAMER_ROW_GAP_EN to insert one idle read
//   cycle after every row except the last. This gives a downstream row buffer
//   a turnaround cycle.
// -----------------------------------------------------------------------------
module fmap_streamer #(
    parameter int In_d_W = 32,
    parameter int W      = 26,
    parameter int H      = 26,
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            clr,
    fmap_streamer_if.slave  bus
);
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [COL_W-1:0]         col_q;
    logic [ROW_W-1:0]         row_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     gap_q;
    logic                     rd_issue;
    logic                     col_last, row_last;
    // Per-read tags delayed by one cycle to line up with mem_rd_data.
    logic                     rd_d1, eol_d1, last_d1;
    logic                     out_valid_q, out_eol_q, done_q;
    logic signed [In_d_W-1:0] out_data_q;

    assign col_last = (col_q == COL_W'(W - 1));
    assign row_last = (row_q == ROW_W'(H - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first. Then no path
    // through the case can leave it unassigned, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        rd_issue = 1'b0;
        case (state_q)
            IDLE:   if (bus.start) state_d = STREAM;
            STREAM: begin
                // hold acts in the same cycle, so a paused read never goes out.
                rd_issue = !bus.hold && !gap_q;
                if (rd_issue && col_last && row_last) state_d = DRAIN;
            end
            // done_q marks the cycle that carries the final pixel.
            DRAIN:  if (done_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef FMAP_STREAMER_ROW_GAP_EN
    // A row-end read, except on the last row, blocks the next cycle's read.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) gap_q <= 1'b0;
        else     gap_q <= rd_issue && col_last && !row_last;
    end
`else
    assign gap_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            rd_d1       <= 1'b0;
            eol_d1      <= 1'b0;
            last_d1     <= 1'b0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rd_d1       <= rd_issue;
            eol_d1      <= rd_issue && col_last;
            last_d1     <= rd_issue && col_last && row_last;
            out_valid_q <= rd_d1;
            out_eol_q   <= eol_d1;
            done_q      <= last_d1;
            if (rd_d1) out_data_q <= bus.mem_rd_data;

            if (state_q == IDLE && bus.start) begin
                addr_q <= bus.base_addr;
                col_q  <= '0;
                row_q  <= '0;
            end else if (rd_issue) begin
                // Row-major order makes the address a plain incrementing
                // counter that wraps modulo 2^ADDR_W.
                addr_q <= addr_q + 1'b1;
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign bus.mem_rd_en = rd_issue;
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_fmap_streamer.sv
// -----------------------------------------------------------------------------
// tb_fmap_streamer
//   Scoreboard bench for fmap_streamer with W=4, H=2. Each accepted frame
//   pushes its expected reads and pixels into queues. Independent monitors on
//   the falling edge pop those queues and compare them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fmap_streamer;
    localparam int D = 32;
    localparam int W = 4;
    localparam int H = 2;
    localparam int A = 10;
`ifdef FMAP_STREAMER_ROW_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    typedef struct {
        logic [A-1:0] addr;
        bit           first;
        bit           row_end;
    } rd_exp_t;

    typedef struct {
        logic signed [D-1:0] data;
        bit                  eol;
        bit                  last;
    } px_exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    fmap_streamer_if #(.In_d_W(D), .ADDR_W(A)) bus ();

    fmap_streamer #(.In_d_W(D), .W(W), .H(H), .ADDR_W(A)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    logic signed [D-1:0] mem [0:(1<<A)-1];
    rd_exp_t             exp_rd[$];
    px_exp_t             exp_px[$];
    int                  rd_cyc_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int accept_cyc = -100;
    int first_rd_cyc = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int frames_expected = 0;
    int prev_rd_cyc = -100;
    bit prev_row_end = 1'b0;
    logic signed [D-1:0] last_data = '0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: one-cycle read latency.
    always @(posedge clk)
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

    // Read monitor. A read is expected exactly when a frame has been accepted,
    // reads remain, hold is low, and the cycle is not a row gap.
    always @(negedge clk) begin
        bit      exp_en;
        rd_exp_t e;
        exp_en = (exp_rd.size() > 0) && (cyc > accept_cyc) && !bus.hold &&
                 !((GAP != 0) && prev_row_end && (cyc == prev_rd_cyc + 1));
        check(bus.mem_rd_en == exp_en, "mem_rd_en", 64'(bus.mem_rd_en), 64'(exp_en));
        if (bus.mem_rd_en && exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            check(bus.mem_addr == e.addr, "mem_addr", 64'(bus.mem_addr), 64'(e.addr));
            if (e.first) first_rd_cyc = cyc;
            prev_row_end = e.row_end;
            prev_rd_cyc  = cyc;
            rd_cyc_q.push_back(cyc);
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        px_exp_t p;
        int      rc;
        if (bus.out_valid) begin
            check(exp_px.size() > 0, "out_valid_expected", 64'(1), 64'(exp_px.size() > 0));
            if (exp_px.size() > 0) begin
                p = exp_px.pop_front();
                check(bus.out_data == p.data, "out_data", 64'(bus.out_data), 64'(p.data));
                check(bus.out_eol == p.eol, "out_eol", 64'(bus.out_eol), 64'(p.eol));
                check(bus.done == p.last, "done", 64'(bus.done), 64'(p.last));
                last_data = p.data;
            end
            if (rd_cyc_q.size() > 0) begin
                rc = rd_cyc_q.pop_front();
                check(cyc == rc + 2, "read_to_out_latency", 64'(cyc - rc), 64'(2));
            end
        end else begin
            check(bus.out_data == last_data && !bus.done && !bus.out_eol, "idle_outputs",
                  {bus.done, bus.out_eol, 30'd0, bus.out_data}, {32'd0, last_data});
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic start_frame(input logic [A-1:0] base, input bit hold_at_start);
        logic [A-1:0] addr;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                addr = base + A'(r * W + c);
                exp_rd.push_back('{addr, (r == 0 && c == 0), (c == W-1 && r != H-1)});
                exp_px.push_back('{mem[addr], (c == W-1), (r == H-1 && c == W-1)});
            end
        accept_cyc = cyc;
        frames_expected++;
        bus.base_addr = base;
        bus.hold      = hold_at_start;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.base_addr = A'($urandom);
    endtask

    // mode 0: quiet, with one ignored start at accept+4.
    // mode 1: random hold and spurious starts.
    // mode 2: hold high for the first three cycles after acceptance.
    task automatic wait_frame(input int mode);
        int  d0;
        bit  finished;
        d0 = done_cnt;
        finished = 1'b0;
        for (int k = 1; k <= 500; k++) begin
            if (done_cnt != d0) begin
                finished = 1'b1;
                break;
            end
            check(bus.busy == 1'b1, "busy_in_frame", 64'(bus.busy), 64'(1));
            case (mode)
                0: begin bus.hold = 1'b0; bus.start = (k == 4); end
                1: begin
                    bus.hold  = ($urandom_range(0, 3) == 0);
                    bus.start = ($urandom_range(0, 5) == 0);
                end
                default: begin bus.hold = (k <= 3); bus.start = 1'b0; end
            endcase
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        check(finished, "frame_done_within_bound", 64'(finished), 64'(1));
        check(bus.busy == 1'b0, "busy_after_done", 64'(bus.busy), 64'(0));
    endtask

    task automatic check_timing(input int first_exp);
        check(first_rd_cyc == first_exp, "first_read_cycle", 64'(first_rd_cyc), 64'(first_exp));
        check(done_cyc == first_exp + W*H - 1 + GAP*(H-1) + 2, "done_cycle",
              64'(done_cyc), 64'(first_exp + W*H - 1 + GAP*(H-1) + 2));
    endtask

    task automatic check_all_zero(input string name);
        check(!bus.mem_rd_en && bus.mem_addr == '0 && !bus.out_valid && bus.out_data == '0 &&
              !bus.out_eol && !bus.busy && !bus.done, name,
              {bus.mem_rd_en, bus.mem_addr, bus.out_valid, bus.out_eol, bus.busy, bus.done,
               bus.out_data}, 64'(0));
    endtask

    initial begin
        for (int i = 0; i < (1 << A); i++) mem[i] = D'($urandom);
        bus.start     = 1'b0;
        bus.hold      = 1'b0;
        bus.base_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        clr = 1'b0;
        @(posedge clk); #1;

        // Plain frame, including an ignored start mid-frame.
        start_frame(A'(16), 1'b0);
        wait_frame(0);
        check_timing(accept_cyc + 1);

        // Back-to-back frame with start and hold together in IDLE.
        start_frame(A'(32), 1'b1);
        wait_frame(2);
        check_timing(accept_cyc + 4);

        // Address wrap past 2^A-1.
        start_frame(A'((1 << A) - 2), 1'b0);
        wait_frame(0);
        check_timing(accept_cyc + 1);

        // Randomized frames with random hold and spurious starts.
        for (int f = 0; f < 10; f++) begin
            start_frame(A'($urandom), bit'($urandom_range(0, 1)));
            wait_frame(1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // Abort mid-frame with clr.
        start_frame(A'(16), 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        exp_rd.delete();
        exp_px.delete();
        rd_cyc_q.delete();
        prev_row_end = 1'b0;
        last_data    = '0;
        frames_expected--;
        clr = 1'b1;
        #1;
        check_all_zero("clr_outputs");
        repeat (2) begin @(posedge clk); #1; end
        clr = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        start_frame(A'(16), 1'b0);
        wait_frame(0);
        check_timing(accept_cyc + 1);

        check(done_cnt == frames_expected, "done_count", 64'(done_cnt), 64'(frames_expected));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
